// File: rtl/pc_control_unit.sv
// PC/EPC owner: next-PC source select, conditional writes, exception vectoring
// and return-from-exception, sequenced by a RUN/TRAP/HALT state machine.
module pc_control_unit #(
    parameter int                 WIDTH      = 32,
    parameter int                 NUM_SRC    = 5,
    parameter int                 SEL_W      = 3,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter int unsigned        EPC_OFFSET = 4,
    parameter int unsigned        VEC0       = 253,
    parameter int unsigned        VEC1       = 254,
    parameter int unsigned        VEC2       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     cond_taken,
    input  logic                     exc_req,
    input  logic [1:0]               exc_cause,
    input  logic                     eret,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         pc_next,
    output logic [WIDTH-1:0]         epc,
    output logic                     exc_active,
    output logic                     halted,
    output logic                     sel_err,
    output logic                     pc_changed
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   epc_q, epc_d;
    logic               sel_err_q, sel_err_d;
    logic               pc_changed_q, pc_changed_d;

    logic               sel_valid;
    logic               we;
    logic [WIDTH-1:0]   vec_addr;

    // Source mux; an out-of-range select yields zero and flags sel_valid low.
    always_comb begin
        pc_next   = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                pc_next   = src_bus[i*WIDTH +: WIDTH];
                sel_valid = 1'b1;
            end
        end
    end

    assign we = pc_write | (pc_write_cond & cond_taken);

    // Cause 3 has no vector of its own and shares the divide-by-zero entry.
    always_comb begin
        case (exc_cause)
            2'd0:    vec_addr = WIDTH'(VEC0);
            2'd1:    vec_addr = WIDTH'(VEC1);
            default: vec_addr = WIDTH'(VEC2);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            epc_q        <= '0;
            sel_err_q    <= 1'b0;
            pc_changed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            sel_err_q    <= sel_err_d;
            pc_changed_q <= pc_changed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        sel_err_d    = 1'b0;
        pc_changed_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    epc_d        = pc_q - WIDTH'(EPC_OFFSET);
                    pc_d         = vec_addr;
                    pc_changed_d = 1'b1;
                    state_d      = ST_TRAP;
                end else if (eret) begin
                    pc_d         = epc_q;
                    pc_changed_d = 1'b1;
                end else if (we && sel_valid) begin
                    pc_d         = pc_next;
                    pc_changed_d = 1'b1;
                end else if (we) begin
                    sel_err_d    = 1'b1;
                end
            end
            // A second request while still trapping is a double fault.
            ST_TRAP: state_d = exc_req ? ST_HALT : ST_RUN;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        exc_active = (state_q == ST_TRAP);
        halted     = (state_q == ST_HALT);
        pc         = pc_q;
        epc        = epc_q;
        sel_err    = sel_err_q;
        pc_changed = pc_changed_q;
    end

endmodule
